// File: rtl/uart_tx_pkg.sv
// Shared constants for the UART transmitter: default baud divider, FIFO sizing
// and the FSM state encodings used by uart_tx.
package uart_tx_pkg;

    localparam int UART_TX_CLK_DIV = 104;
    localparam int UART_TX_FIFO_AW = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter. The full and empty flags come from a
// registered occupancy count, so a push that sees full is dropped even if a pop happens in the same cycle.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int AW = UART_TX_FIFO_AW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == DEPTH);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rdata   = mem[rd_ptr];
    assign do_push = rstn && push && !full;
    assign do_pop  = rstn && pop && !empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; reset empties the FIFO by clearing pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames, CLK_DIV clocks per bit, fed from a small FIFO.
// Stop-to-start transitions pop the next byte directly so queued frames run back-to-back.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_DIV = UART_TX_CLK_DIV,
    parameter int FIFO_AW = UART_TX_FIFO_AW
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic [7:0] rx_i,
    input  logic       rx_i_v,
    output logic       full_o,
    output logic       ovf_o,
    output logic       busy_o,
    output logic       tx_o
);

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

    logic [1:0]         state;
    logic [15:0]        baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;
    logic               baud_end;
    logic               fifo_pop;
    logic               fifo_empty;
    logic [7:0]         fifo_rdata;
    logic [FIFO_AW:0]   fifo_count;

    uart_tx_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk   (clk_i),
        .rstn  (rstn_i),
        .push  (rx_i_v),
        .pop   (fifo_pop),
        .wdata (rx_i),
        .rdata (fifo_rdata),
        .full  (full_o),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign fifo_pop = !fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && baud_end));

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        shift    <= fifo_rdata;
                        baud_cnt <= '0;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                ST_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (fifo_pop) begin
                            shift <= fifo_rdata;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Line and status are registered from the current state, so the line trails the FSM by one clock.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            tx_o   <= 1'b1;
            busy_o <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            case (state)
                ST_START: tx_o <= 1'b0;
                ST_DATA:  tx_o <= shift[0];
                default:  tx_o <= 1'b1;
            endcase
            busy_o <= (state != ST_IDLE) || (fifo_count != '0);
            ovf_o  <= rx_i_v && full_o;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with CLK_DIV=4 and a 4-deep FIFO: bytes expected on the line are queued
// as they are written and compared by a frame decoder watching tx_o.
module tb_uart_tx;

    localparam int DIV = 4;
    localparam int AW  = 2;

    logic       clk = 1'b0;
    logic       rstn_i = 1'b0;
    logic [7:0] rx_i = 8'h00;
    logic       rx_i_v = 1'b0;
    logic       full_o;
    logic       ovf_o;
    logic       busy_o;
    logic       tx_o;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         starts[$];
    int         cyc = 0;
    logic       in_frame = 1'b0;
    int         pos = 0;
    logic [7:0] shreg = 8'h00;
    logic [7:0] exp_b;

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_DIV(DIV),
        .FIFO_AW(AW)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn_i),
        .rx_i   (rx_i),
        .rx_i_v (rx_i_v),
        .full_o (full_o),
        .ovf_o  (ovf_o),
        .busy_o (busy_o),
        .tx_o   (tx_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; one write request per call.
    task automatic applyStimulus(input logic [7:0] b, input bit accept);
        rx_i   = b;
        rx_i_v = 1'b1;
        if (accept) exp_q.push_back(b);
        @(negedge clk);
        rx_i_v = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitIdle(input int budget, output int k);
        k = 0;
        while (busy_o !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("idle_within_budget", 32'(busy_o), 0);
    endtask

    // Frame decoder: samples the line just after each rising edge, mid-bit for data.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rstn_i) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (tx_o == 1'b0) begin
                in_frame = 1'b1;
                pos = 0;
                starts.push_back(cyc);
            end
        end else begin
            pos++;
        end
        if (in_frame) begin
            if (pos == 2) checkOutput("start_bit", 32'(tx_o), 0);
            if (pos >= 6 && pos <= 34 && ((pos - 6) % 4) == 0) shreg = {tx_o, shreg[7:1]};
            if (pos == 38) begin
                checkOutput("stop_bit", 32'(tx_o), 1);
                checkOutput("frame_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    checkOutput("rx_byte", 32'(shreg), 32'(exp_b));
                end
            end
            if (pos == 39) in_frame = 1'b0;
        end
    end

    initial begin
        int k;
        int kk;
        int gap;
        bit ovf_seen;

        // Reset with a write held active; it must not be taken.
        rstn_i = 1'b0;
        rx_i   = 8'hEE;
        rx_i_v = 1'b1;
        waitCycles(3);
        checkOutput("rst_tx", 32'(tx_o), 1);
        checkOutput("rst_full", 32'(full_o), 0);
        checkOutput("rst_ovf", 32'(ovf_o), 0);
        checkOutput("rst_busy", 32'(busy_o), 0);
        rstn_i = 1'b1;
        rx_i_v = 1'b0;
        waitCycles(3);
        checkOutput("rst_write_ignored", 32'(busy_o), 0);
        checkOutput("tx_idle_high", 32'(tx_o), 1);

        // Single byte: latency, frame and busy release.
        applyStimulus(8'h55, 1'b1);
        checkOutput("lat_n0_tx", 32'(tx_o), 1);
        waitCycles(1);
        checkOutput("lat_n1_tx", 32'(tx_o), 1);
        checkOutput("busy_high", 32'(busy_o), 1);
        waitCycles(1);
        checkOutput("lat_n2_tx", 32'(tx_o), 0);
        waitIdle(100, kk);
        checkOutput("busy_fall_cycle", 32'(2 + kk), 42);

        // Two consecutive writes run back-to-back on the line.
        starts.delete();
        applyStimulus(8'hA3, 1'b1);
        applyStimulus(8'h0F, 1'b1);
        waitIdle(200, kk);
        checkOutput("frames_seen", 32'(starts.size()), 2);
        gap = (starts.size() >= 2) ? starts[1] - starts[0] : -1;
        checkOutput("b2b_gap", 32'(gap), 40);

        // Fill behind an in-flight frame, then overflow, then write on the pop cycle.
        applyStimulus(8'h11, 1'b1);
        waitCycles(5);
        applyStimulus(8'h21, 1'b1);
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h23, 1'b1);
        checkOutput("full_not_yet", 32'(full_o), 0);
        applyStimulus(8'h24, 1'b1);
        checkOutput("full_after_4", 32'(full_o), 1);
        applyStimulus(8'h25, 1'b0);
        checkOutput("ovf_pulse", 32'(ovf_o), 1);
        checkOutput("full_held", 32'(full_o), 1);
        waitCycles(1);
        checkOutput("ovf_one_cycle", 32'(ovf_o), 0);
        waitCycles(29);
        checkOutput("full_before_pop", 32'(full_o), 1);
        applyStimulus(8'h77, 1'b0);
        checkOutput("ovf_on_pop", 32'(ovf_o), 1);
        checkOutput("full_after_pop", 32'(full_o), 0);
        waitIdle(400, kk);

        // Reset during data bit 3 with two bytes queued.
        applyStimulus(8'h31, 1'b0);
        applyStimulus(8'h32, 1'b0);
        applyStimulus(8'h33, 1'b0);
        waitCycles(16);
        rstn_i = 1'b0;
        waitCycles(1);
        rstn_i = 1'b1;
        checkOutput("midrst_tx", 32'(tx_o), 1);
        checkOutput("midrst_busy", 32'(busy_o), 0);
        checkOutput("midrst_full", 32'(full_o), 0);
        starts.delete();
        waitCycles(100);
        checkOutput("no_frames_after_reset", 32'(starts.size()), 0);
        checkOutput("busy_after_reset", 32'(busy_o), 0);

        // Paced stream through the pointer wrap.
        ovf_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(8'(i), 1'b1);
            repeat (31) begin
                @(negedge clk);
                if (ovf_o) ovf_seen = 1'b1;
            end
        end
        waitIdle(200, kk);
        checkOutput("stream_no_ovf", 32'(ovf_seen), 0);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
